// File: rtl/mem_stage_if.sv
// Data-bus request/response bundle between the memory stage and the data cache/bus.
interface mem_stage_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    output dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: stage register, alignment exceptions, single-outstanding
// data-bus request FSM and load-data extraction.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_val3,
  input  logic [31:0] e_valt,
  input  logic [5:0]  e_icode,
  input  logic [5:0]  e_acode,
  input  logic [4:0]  e_dst,
  input  logic [5:0]  e_excCode,
  input  logic        e_inDelaySlot,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic        exception,
  mem_stage_if.master dbus,
  output logic [31:0] m_pc,
  output logic [31:0] m_valW,
  output logic [4:0]  m_dst,
  output logic [5:0]  m_icode,
  output logic [5:0]  m_excCode,
  output logic        m_inDelaySlot,
  output logic        m_busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  localparam logic [OPW-1:0] OP_LB  = 6'h20;
  localparam logic [OPW-1:0] OP_LH  = 6'h21;
  localparam logic [OPW-1:0] OP_LW  = 6'h23;
  localparam logic [OPW-1:0] OP_LBU = 6'h24;
  localparam logic [OPW-1:0] OP_LHU = 6'h25;
  localparam logic [OPW-1:0] OP_SB  = 6'h28;
  localparam logic [OPW-1:0] OP_SH  = 6'h29;
  localparam logic [OPW-1:0] OP_SW  = 6'h2b;

  localparam logic [OPW-1:0] EXC_ADEL = 6'b100100;
  localparam logic [OPW-1:0] EXC_ADES = 6'b100101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   busy_q, busy_d;

  logic [XLEN-1:0] m_pc_q, m_pc_d;
  logic [XLEN-1:0] m_val3_q, m_val3_d;
  logic [XLEN-1:0] m_valt_q, m_valt_d;
  logic [OPW-1:0]  m_icode_q, m_icode_d;
  logic [OPW-1:0]  m_acode_q, m_acode_d;
  logic [OPW-1:0]  m_exc_q, m_exc_d;
  logic [4:0]      m_dst_q, m_dst_d;
  logic            m_ds_q, m_ds_d;

  logic [XLEN-1:0] rbuf_q, rbuf_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_data_q, req_data_d;
  logic [3:0]      req_strb_q, req_strb_d;

  logic            e_is_load, e_is_store, e_misalign;
  logic            load_en, issue;
  logic [OPW-1:0]  e_exc;
  logic [3:0]      e_strb;
  logic [XLEN-1:0] e_wdata;

  logic [15:0]     ld_half;
  logic [7:0]      ld_byte;
  logic [XLEN-1:0] valw_c;

  // Incoming op classification and exception resolution (earlier exceptions win)
  always_comb begin
    e_is_load  = e_icode inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    e_is_store = e_icode inside {OP_SW, OP_SH, OP_SB};
    e_misalign = ((e_icode == OP_LW || e_icode == OP_SW) && (e_val3[1:0] != 2'b00)) ||
                 ((e_icode == OP_LH || e_icode == OP_LHU || e_icode == OP_SH) && e_val3[0]);
    e_exc = e_excCode;
    if (!e_excCode[5] && e_misalign) begin
      e_exc = e_is_store ? EXC_ADES : EXC_ADEL;
    end
    load_en = !exception && !M_stall && !busy_q && !M_bubble;
    issue   = load_en && (e_is_load || e_is_store) && !e_exc[5];
  end

  // Byte-lane strobe and replicated write data for the incoming store
  always_comb begin
    e_strb  = 4'b0000;
    e_wdata = '0;
    case (e_icode)
      OP_SW: begin
        e_strb  = 4'b1111;
        e_wdata = e_valt;
      end
      OP_SH: begin
        e_strb  = 4'(4'b0011 << {e_val3[1], 1'b0});
        e_wdata = {2{e_valt[15:0]}};
      end
      OP_SB: begin
        e_strb  = 4'(4'b0001 << e_val3[1:0]);
        e_wdata = {4{e_valt[7:0]}};
      end
      default: ;
    endcase
  end

  // Stage register: flush > hold > bubble > load; a bubble keeps the pc
  always_comb begin
    m_pc_d    = m_pc_q;
    m_val3_d  = m_val3_q;
    m_valt_d  = m_valt_q;
    m_icode_d = m_icode_q;
    m_acode_d = m_acode_q;
    m_exc_d   = m_exc_q;
    m_dst_d   = m_dst_q;
    m_ds_d    = m_ds_q;
    if (exception || (!M_stall && !busy_q && M_bubble)) begin
      m_val3_d  = '0;
      m_valt_d  = '0;
      m_icode_d = '0;
      m_acode_d = '0;
      m_exc_d   = '0;
      m_dst_d   = '0;
      m_ds_d    = 1'b0;
    end else if (load_en) begin
      m_pc_d    = e_pc;
      m_val3_d  = e_val3;
      m_valt_d  = e_valt;
      m_icode_d = e_icode;
      m_acode_d = e_acode;
      m_exc_d   = e_exc;
      m_dst_d   = e_dst;
      m_ds_d    = e_inDelaySlot;
    end
  end

  // Bus FSM: a flushed request stays on the bus until its response drains
  always_comb begin
    state_d    = state_q;
    rbuf_d     = rbuf_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_strb_d = req_strb_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = WAIT;
          req_addr_d = {e_val3[31:2], 2'b00};
          req_data_d = e_wdata;
          req_strb_d = e_strb;
        end
      end
      WAIT: begin
        if (dbus.dresp_data_ok) begin
          if (!exception) begin
            rbuf_d = dbus.dresp_data;
          end
          state_d = IDLE;
        end else if (exception) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dbus.dresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Writeback value selection from the read buffer
  always_comb begin
    ld_half = m_val3_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
    case (m_val3_q[1:0])
      2'd0:    ld_byte = rbuf_q[7:0];
      2'd1:    ld_byte = rbuf_q[15:8];
      2'd2:    ld_byte = rbuf_q[23:16];
      default: ld_byte = rbuf_q[31:24];
    endcase
    case (m_icode_q)
      OP_LW:                valw_c = rbuf_q;
      OP_LH:                valw_c = {{16{ld_half[15]}}, ld_half};
      OP_LHU:               valw_c = {16'h0000, ld_half};
      OP_LB:                valw_c = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:               valw_c = {24'h000000, ld_byte};
      OP_SW, OP_SH, OP_SB:  valw_c = '0;
      default:              valw_c = m_val3_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      m_pc_q     <= '0;
      m_val3_q   <= '0;
      m_valt_q   <= '0;
      m_icode_q  <= '0;
      m_acode_q  <= '0;
      m_exc_q    <= '0;
      m_dst_q    <= '0;
      m_ds_q     <= 1'b0;
      rbuf_q     <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_strb_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      m_pc_q     <= m_pc_d;
      m_val3_q   <= m_val3_d;
      m_valt_q   <= m_valt_d;
      m_icode_q  <= m_icode_d;
      m_acode_q  <= m_acode_d;
      m_exc_q    <= m_exc_d;
      m_dst_q    <= m_dst_d;
      m_ds_q     <= m_ds_d;
      rbuf_q     <= rbuf_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_strb_q <= req_strb_d;
    end
  end

  // Carried stage fields with no consumer inside this stage
  logic unused_stage;
  assign unused_stage = ^{m_acode_q, m_valt_q};

  assign dbus.dreq_valid  = busy_q;
  assign dbus.dreq_addr   = req_addr_q;
  assign dbus.dreq_strobe = req_strb_q;
  assign dbus.dreq_data   = req_data_q;

  assign m_pc          = m_pc_q;
  assign m_valW        = valw_c;
  assign m_dst         = m_dst_q;
  assign m_icode       = m_icode_q;
  assign m_excCode     = m_exc_q;
  assign m_inDelaySlot = m_ds_q;
  assign m_busy        = busy_q;

endmodule
